conv_window_scheduler: RTL and testbench

CONV_WINDOW_SCHEDULER -- requirements
Module: conv_window_scheduler

---
 rtl/conv_window_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// Frame-pass scheduler: for every pixel, gathers the 3x3 neighbourhood from pixel RAM,
// presents it to a compute unit, and writes the returned result into the output frame.
module conv_window_scheduler #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int OUT_BASE = 307200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [19:0]       mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [8:0]        mem_wdata,
  input  logic [8:0]        mem_rdata,
  output logic signed [8:0] win_data [0:8],
  output logic              win_valid,
  input  logic              win_ready,
  input  logic              res_valid,
  input  logic [8:0]        res_data,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HANDOFF, WAIT_RES, WRITE, DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);

  state_t            r_state;
  logic [9:0]        r_x;
  logic [8:0]        r_y;
  logic [3:0]        r_k;
  logic              r_cap_en;
  logic [3:0]        r_cap_k;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [19:0]       r_mem_addr;
  logic [8:0]        r_mem_wdata;
  logic              r_win_valid;
  logic signed [8:0] r_win [0:8];

  logic [9:0]        w_tap_x;
  logic [8:0]        w_tap_y;
  logic [3:0]        w_tap_k;
  logic              w_tap_inb;
  logic [19:0]       w_tap_addr;
  logic [9:0]        w_nx;
  logic [8:0]        w_ny;
  logic              w_last;
  int                w_tx;
  int                w_ty;

  // Memory strobes are registered, so the tap issued next cycle is resolved here.
  always_comb begin
    w_last = (r_x == X_LAST) && (r_y == Y_LAST);
    w_nx   = r_x + 10'd1;
    w_ny   = r_y;
    if (r_x == X_LAST) begin
      w_nx = '0;
      w_ny = r_y + 9'd1;
    end
    w_tap_x = r_x;
    w_tap_y = r_y;
    w_tap_k = r_k + 4'd1;
    if (r_state == IDLE) begin
      w_tap_x = '0;
      w_tap_y = '0;
      w_tap_k = '0;
    end else if (r_state == WRITE) begin
      w_tap_x = w_nx;
      w_tap_y = w_ny;
      w_tap_k = '0;
    end
    w_tx       = int'(w_tap_x) + int'(w_tap_k) % 3 - 1;
    w_ty       = int'(w_tap_y) + int'(w_tap_k) / 3 - 1;
    w_tap_inb  = (w_tx >= 0) && (w_tx < IMG_W) && (w_ty >= 0) && (w_ty < IMG_H);
    w_tap_addr = w_tap_inb ? 20'(w_ty * IMG_W + w_tx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_k         <= '0;
      r_cap_en    <= 1'b0;
      r_cap_k     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_win_valid <= 1'b0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else begin
      // Read data arrives one cycle after the strobe; land it in the tap that asked for it.
      r_cap_en <= 1'b0;
      if (r_cap_en) r_win[r_cap_k] <= $signed(mem_rdata);
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= FETCH;
            r_busy     <= 1'b1;
            r_x        <= '0;
            r_y        <= '0;
            r_k        <= '0;
            r_mem_re   <= w_tap_inb;
            r_mem_addr <= w_tap_addr;
          end
        end
        FETCH: begin
          if (!r_mem_re) r_win[r_k] <= '0;
          r_cap_en <= r_mem_re;
          r_cap_k  <= r_k;
          if (r_k == 4'd8) begin
            r_state  <= DRAIN;
            r_mem_re <= 1'b0;
          end else begin
            r_k        <= r_k + 4'd1;
            r_mem_re   <= w_tap_inb;
            r_mem_addr <= w_tap_addr;
          end
        end
        DRAIN: begin
          r_state     <= HANDOFF;
          r_win_valid <= 1'b1;
        end
        HANDOFF: begin
          if (win_ready) begin
            r_state     <= WAIT_RES;
            r_win_valid <= 1'b0;
          end
        end
        WAIT_RES: begin
          if (res_valid) begin
            r_state     <= WRITE;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= 20'(OUT_BASE + int'(r_y) * IMG_W + int'(r_x));
            r_mem_wdata <= res_data;
          end
        end
        WRITE: begin
          r_mem_we <= 1'b0;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= FETCH;
            r_x        <= w_nx;
            r_y        <= w_ny;
            r_k        <= '0;
            r_mem_re   <= w_tap_inb;
            r_mem_addr <= w_tap_addr;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_addr  = r_mem_addr;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign win_valid = r_win_valid;
  assign pix_x     = r_x;
  assign pix_y     = r_y;

  for (genvar gi = 0; gi < 9; gi++) begin : g_win
    assign win_data[gi] = r_win[gi];
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler on a 4x3 image: table-checked windows, stall/reset/start
// sequences, and randomized frames scored against a neighbourhood model built from the RAM image.
module tb_conv_window_scheduler;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int OB   = 64;

  logic              clk = 1'b0;
  logic              reset, start, busy, done, mem_re, mem_we, win_valid, win_ready, res_valid;
  logic [19:0]       mem_addr;
  logic [8:0]        mem_wdata, mem_rdata, res_data;
  logic signed [8:0] win_data [0:8];
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;

  always #5 clk = ~clk;

  conv_window_scheduler #(.IMG_W(W), .IMG_H(H), .OUT_BASE(OB)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .win_data(win_data), .win_valid(win_valid),
    .win_ready(win_ready), .res_valid(res_valid), .res_data(res_data),
    .pix_x(pix_x), .pix_y(pix_y)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] ram [0:NPIX-1];
  logic [8:0] exp_res [NPIX];
  int         exp_reads;

  function automatic int model_tap(input int x, input int y, input int k);
    int tx, ty;
    tx = x + k % 3 - 1;
    ty = y + k / 3 - 1;
    if (tx < 0 || tx >= W || ty < 0 || ty >= H) return 0;
    return int'(ram[ty * W + tx]);
  endfunction

  function automatic logic [8:0][8:0] pack_model(input int x, input int y);
    logic [8:0][8:0] w;
    for (int k = 0; k < 9; k++) w[k] = 9'(model_tap(x, y, k));
    return w;
  endfunction

  function automatic logic [8:0][8:0] pack_dut();
    logic [8:0][8:0] w;
    for (int k = 0; k < 9; k++) w[k] = win_data[k];
    return w;
  endfunction

  function automatic logic [8:0] mix(input logic [8:0][8:0] w);
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) s += (k + 1) * int'(w[k]);
    return 9'(s);
  endfunction

  // ---------------- pixel RAM ----------------
  always @(posedge clk)
    mem_rdata <= (mem_re && mem_addr < 20'(NPIX)) ? ram[mem_addr[3:0]] : 9'h1ff;

  // ---------------- monitor / scoreboard ----------------
  int              cu_mode = 0;
  int              wr_base = 0, rd_base = 0, done_base = 0;
  int              cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, last_wr_cyc = 0;
  logic [11:0]     cur_mask = '0;
  logic [8:0][8:0] obs_win [NPIX];
  logic [11:0]     obs_mask [NPIX];
  bit              res_pend = 1'b0;
  int              res_wait = 0;
  logic [8:0]      res_q = '0;

  always @(negedge clk) begin
    logic [8:0][8:0] w;
    int p, widx;
    cyc++;
    if (reset) cur_mask = '0;
    if (res_pend && res_valid) res_pend = 1'b0;
    if (mem_re && mem_we) check("re_we_overlap", 1, 0);
    if (win_valid) check("handoff_no_strobe", int'(mem_re | mem_we), 0);
    if (mem_re) begin
      rd_cnt++;
      check("rd_in_frame", int'(mem_addr < 20'(NPIX)), 1);
      if (mem_addr < 20'(NPIX)) cur_mask[mem_addr[3:0]] = 1'b1;
    end
    if (win_valid && win_ready) begin
      w = pack_dut();
      p = int'(pix_y) * W + int'(pix_x);
      if (p < NPIX) begin
        obs_win[p]  = w;
        obs_mask[p] = cur_mask;
        for (int k = 0; k < 9; k++)
          check("win_vs_model", int'(w[k]), model_tap(int'(pix_x), int'(pix_y), k));
      end else begin
        check("pix_range", p, NPIX - 1);
      end
      cur_mask = '0;
      res_q    = (cu_mode == 2) ? mix(w) : w[4];
      res_wait = (cu_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      res_pend = 1'b1;
    end
    if (mem_we) begin
      widx = wr_cnt - wr_base;
      check("wr_addr", int'(mem_addr), OB + widx);
      if (widx < NPIX) check("wr_data", int'(mem_wdata), int'(exp_res[widx]));
      if (cu_mode == 1 && widx > 0) check("wr_spacing", cyc - last_wr_cyc, 13);
      last_wr_cyc = cyc;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      check("busy_low_in_done", int'(busy), 0);
    end
  end

  // ---------------- compute-unit driver ----------------
  initial begin
    bit armed;
    int left;
    armed = 1'b0;
    left = 0;
    win_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      win_ready = 1'b0;
      res_valid = 1'b0;
      if (!res_pend) armed = 1'b0;
      else if (!armed) begin
        armed = 1'b1;
        left  = res_wait;
      end
      if (cu_mode != 0) begin
        win_ready = (cu_mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
        if (armed) begin
          if (left == 0) begin
            res_valid = 1'b1;
            res_data  = res_q;
          end else begin
            left--;
          end
        end else if (cu_mode == 2 && win_valid) begin
          res_valid = ($urandom_range(0, 1) == 1);
          res_data  = 9'($urandom);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]      px;
    logic [3:0]      py;
    logic [11:0]     mask;
    logic [8:0][8:0] win;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input int px, input int py, input int mask,
                              input int w0, input int w1, input int w2, input int w3,
                              input int w4, input int w5, input int w6, input int w7,
                              input int w8);
    vec_t v;
    v.px = 4'(px);
    v.py = 4'(py);
    v.mask = 12'(mask);
    v.win[0] = 9'(w0); v.win[1] = 9'(w1); v.win[2] = 9'(w2);
    v.win[3] = 9'(w3); v.win[4] = 9'(w4); v.win[5] = 9'(w5);
    v.win[6] = 9'(w6); v.win[7] = 9'(w7); v.win[8] = 9'(w8);
    return v;
  endfunction

  task automatic run_table();
    int p;
    for (int i = 0; i < 5; i++) begin
      p = int'(tbl[i].py) * W + int'(tbl[i].px);
      check("tbl_read_mask", int'(obs_mask[p]), int'(tbl[i].mask));
      for (int k = 0; k < 9; k++) check("tbl_win", int'(obs_win[p][k]), int'(tbl[i].win[k]));
    end
  endtask

  // ---------------- frame helpers ----------------
  task automatic prep(input int mode);
    exp_reads = 0;
    for (int p = 0; p < NPIX; p++) begin
      exp_res[p] = (mode == 2) ? mix(pack_model(p % W, p / W)) : ram[p];
      for (int k = 0; k < 9; k++)
        if ((p % W) + k % 3 - 1 >= 0 && (p % W) + k % 3 - 1 < W &&
            (p / W) + k / 3 - 1 >= 0 && (p / W) + k / 3 - 1 < H) exp_reads++;
    end
    wr_base   = wr_cnt;
    rd_base   = rd_cnt;
    done_base = done_cnt;
    cu_mode   = mode;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame();
    int c;
    c = 0;
    while (done_cnt == done_base && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("frame_completes", int'(done_cnt > done_base), 1);
    repeat (4) @(negedge clk);
    check("writes_per_frame", wr_cnt - wr_base, NPIX);
    check("done_pulses", done_cnt - done_base, 1);
    check("busy_after_done", int'(busy), 0);
    check("reads_per_frame", rd_cnt - rd_base, exp_reads);
  endtask

  task automatic check_reset_state();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_re", int'(mem_re), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_win_valid", int'(win_valid), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_pix_x", int'(pix_x), 0);
    check("rst_pix_y", int'(pix_y), 0);
    check("rst_window_zero", int'(pack_dut() == '0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [8:0][8:0] snap;
    int c, rd_snap;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NPIX; i++) ram[i] = 9'(i);
    tbl[0] = mk(0, 0, 'h033, 0, 0, 0, 0, 0, 1, 0, 4, 5);
    tbl[1] = mk(3, 2, 'hCC0, 6, 7, 0, 10, 11, 0, 0, 0, 0);
    tbl[2] = mk(1, 1, 'h777, 0, 1, 2, 4, 5, 6, 8, 9, 10);
    tbl[3] = mk(3, 0, 'h0CC, 0, 0, 0, 2, 3, 0, 6, 7, 0);
    tbl[4] = mk(0, 2, 'h330, 0, 4, 5, 0, 8, 9, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    @(negedge clk);

    // Echo frame on RAM[i]=i, with a stray start while busy.
    prep(1);
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    @(negedge clk);
    pulse_start();
    check("ignored_start_x", int'(pix_x), 0);
    check("ignored_start_y", int'(pix_y), 0);
    check("ignored_start_busy", int'(busy), 1);
    finish_frame();
    run_table();

    // Compute unit holds off for several cycles in HANDOFF.
    for (int i = 0; i < NPIX; i++) ram[i] = 9'((i * 37 + 5) % 512);
    prep(0);
    pulse_start();
    c = 0;
    while (!win_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("reach_handoff", int'(win_valid), 1);
    snap = pack_dut();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", int'(win_valid), 1);
      check("stall_data", int'(pack_dut() == snap), 1);
    end
    cu_mode = 1;
    finish_frame();

    // Reset during the 4th FETCH cycle, then a clean restart.
    for (int i = 0; i < NPIX; i++) ram[i] = 9'(i);
    prep(1);
    pulse_start();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    rd_snap = rd_cnt;
    repeat (2) @(negedge clk);
    check("abort_no_reads", rd_cnt - rd_snap, 0);
    check("abort_no_writes", wr_cnt - wr_base, 0);
    reset = 1'b0;
    @(negedge clk);
    prep(1);
    pulse_start();
    check("restart_x", int'(pix_x), 0);
    check("restart_y", int'(pix_y), 0);
    check("restart_busy", int'(busy), 1);
    finish_frame();
    run_table();

    // Randomized frames: random RAM, random ready/result timing, junk res_valid in HANDOFF.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++) ram[i] = 9'($urandom);
      prep(2);
      pulse_start();
      finish_frame();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
